tdm_stim_arbiter: RTL and testbench

// - Collects stimulus-current injections from NUM_REQ requesters and delivers them to tdm_controller.
// - Keeps one pending-current accumulator per neuron; requesters share it through a round-robin arbiter.
// - Tracks the controller's TDM slot pointer. Each time a neuron's slot comes up, drives its pending

---
 rtl/tdm_stim_arbiter_pkg.sv | 39 +++
 rtl/tdm_stim_arbiter_rr_arbiter.sv | 41 ++++
 rtl/tdm_stim_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_tdm_stim_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_stim_arbiter_pkg.sv
// Shared types and saturating-arithmetic helpers for the TDM stimulus arbiter.
// Provides package tdm_pkg: the sequencer state type, the Q4.12 saturation
// bounds and the saturating signed adder used for accumulation and collisions.
package tdm_pkg;

  // Current word width (signed Q4.12, 4096 = 1.0)
  localparam int DW = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // Signed add with one guard bit; overflow when the two top bits disagree.
  function automatic logic sat_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    return (s[DW] != s[DW-1]);
  endfunction

  // Signed add clamped to [SAT_MIN, SAT_MAX].
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) begin
      if (s[DW]) begin
        return SAT_MIN;
      end else begin
        return SAT_MAX;
      end
    end else begin
      return s[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/tdm_stim_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after rr_ptr.
// Purely combinational; the owner keeps the rotating pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // Scan requesters starting at rr_ptr, wrapping once, and take the first valid one.
  always_comb begin
    logic           w_found;
    int             w_k;
    logic [IDX_W-1:0] w_kidx;
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_k       = 0;
    w_kidx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = int'(rr_ptr) + i;
      if (w_k >= NUM_REQ) begin
        w_k = w_k - NUM_REQ;
      end else begin
        w_k = w_k;
      end
      w_kidx = IDX_W'(w_k);
      if (!w_found && valid[w_kidx]) begin
        grant[w_kidx] = 1'b1;
        grant_idx     = w_kidx;
        w_found       = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/tdm_stim_arbiter.sv
// TDM stimulus arbiter: requesters inject signed currents into per-neuron
// accumulators; each neuron's pending current is delivered once on i_stim
// when the controller's slot pointer reaches it, then cleared.
// Optional feature macro: STIM_STATS_EN adds grant/drop/saturation counters.
module tdm_stim_arbiter
  import tdm_pkg::*;
#(
  parameter int NEURON_COUNT = 500,
  parameter int DATA_WIDTH   = DW,
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = $clog2(NEURON_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ID_W-1:0]       req_id,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_cur,
  input  logic [ID_W-1:0]               slot_id,
  input  logic                          slot_valid,
  output logic [DATA_WIDTH-1:0]         i_stim,
  output logic                          init_done
`ifdef STIM_STATS_EN
  ,
  output logic [31:0]                   grant_cnt,
  output logic [31:0]                   drop_cnt,
  output logic [31:0]                   sat_cnt
`endif
);

  localparam int              IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NEURON_COUNT - 1);
  localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(NUM_REQ - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_clr_ptr;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_i_stim;
  logic                  r_init_done;
  logic [DATA_WIDTH-1:0] r_acc [NEURON_COUNT];

  logic                  w_run;
  logic                  w_clr_en;
  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_grant_idx;
  logic                  w_xfer;
  logic [ID_W-1:0]       w_g_id;
  logic [DATA_WIDTH-1:0] w_g_cur;
  logic                  w_g_in_range;
  logic                  w_slot_ok;
  logic                  w_dlv;
  logic                  w_coll;
  logic                  w_acc_we;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_ovf;

  // Requesters see no ready while in reset or while the accumulators are being cleared.
  assign w_run     = rst && (r_state == RUN);
  assign w_clr_en  = (r_state == INIT);
  assign req_ready = w_grant & {NUM_REQ{w_run}};
  assign w_xfer    = w_run && (|w_grant);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .valid     (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // Select the id and current of the granted requester.
  always_comb begin
    w_g_id  = '0;
    w_g_cur = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_g_id  = req_id[k*ID_W +: ID_W];
        w_g_cur = req_cur[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_g_id  = w_g_id;
        w_g_cur = w_g_cur;
      end
    end
  end

  // Out-of-range ids are still accepted but never touch the accumulator array.
  assign w_g_in_range = (w_g_id <= LAST_ID);
  assign w_slot_ok    = (slot_id <= LAST_ID);
  assign w_dlv        = w_run && slot_valid && w_slot_ok;
  assign w_sum        = sat_add(r_acc[w_g_id], w_g_cur);
  assign w_ovf        = sat_ovf(r_acc[w_g_id], w_g_cur);
  // A collision folds the injection straight into the delivered value.
  assign w_coll       = w_dlv && w_xfer && w_g_in_range && (w_g_id == slot_id);
  assign w_acc_we     = w_xfer && w_g_in_range && !w_coll;

  // Sequencer next state: INIT walks every entry once, then RUN until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT: begin
        if (r_clr_ptr == LAST_ID) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = INIT;
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  // Sequencer state, clear pointer and init_done flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= INIT;
      r_clr_ptr   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == RUN);
      if (r_state == INIT) begin
        r_clr_ptr <= r_clr_ptr + ID_W'(1);
      end
    end
  end

  // Round-robin pointer moves past the winner only when a transfer happens.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_grant_idx == LAST_REQ) ? '0 : w_grant_idx + IDX_W'(1);
    end
  end

  // Accumulator array; the delivery clear is last so a collision leaves the entry at zero.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_acc[r_clr_ptr] <= '0;
    end
    if (w_acc_we) begin
      r_acc[w_g_id] <= w_sum;
    end
    if (w_dlv) begin
      r_acc[slot_id] <= '0;
    end
  end

  // Delivery register: one-cycle latency from slot_id to i_stim.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i_stim <= '0;
    end else if (w_dlv) begin
      r_i_stim <= w_coll ? w_sum : r_acc[slot_id];
    end else begin
      r_i_stim <= '0;
    end
  end

  assign i_stim    = r_i_stim;
  assign init_done = r_init_done;

`ifdef STIM_STATS_EN
  logic [31:0] r_grant_cnt;
  logic [31:0] r_drop_cnt;
  logic [31:0] r_sat_cnt;

  // Event counters; transfers only occur in RUN, so they naturally hold during INIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant_cnt <= 32'd0;
      r_drop_cnt  <= 32'd0;
      r_sat_cnt   <= 32'd0;
    end else begin
      if (w_xfer) begin
        r_grant_cnt <= r_grant_cnt + 32'd1;
      end
      if (w_xfer && !w_g_in_range) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
      if (w_xfer && w_g_in_range && w_ovf) begin
        r_sat_cnt <= r_sat_cnt + 32'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign sat_cnt   = r_sat_cnt;
`endif

endmodule

// File: tb/tb_tdm_stim_arbiter.sv
// Self-checking bench for tdm_stim_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model built from integer accumulators and a priority index.
module tb_tdm_stim_arbiter;

  localparam int N  = 500;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*IW-1:0]  req_id;
  logic [NR*DW-1:0]  req_cur;
  logic [IW-1:0]     slot_id;
  logic              slot_valid;
  logic [DW-1:0]     i_stim;
  logic              init_done;
`ifdef STIM_STATS_EN
  logic [31:0]       grant_cnt;
  logic [31:0]       drop_cnt;
  logic [31:0]       sat_cnt;
`endif

  always #5 clk = ~clk;

  tdm_stim_arbiter #(
    .NEURON_COUNT (N),
    .DATA_WIDTH   (DW),
    .NUM_REQ      (NR),
    .ID_W         (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_id     (req_id),
    .req_cur    (req_cur),
    .slot_id    (slot_id),
    .slot_valid (slot_valid),
    .i_stim     (i_stim),
    .init_done  (init_done)
`ifdef STIM_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .drop_cnt   (drop_cnt),
    .sat_cnt    (sat_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int          m_acc [N];
  bit          m_known = 1'b0;
  bit          m_run;
  bit          m_done;
  int          m_init_left;
  int          m_rr;
  int          m_stim;
  int          m_last_grant = -1;
  int unsigned m_gcnt, m_dcnt, m_scnt;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int id_of(input int k);
    return int'(req_id[k*IW +: IW]);
  endfunction

  function automatic int cur_of(input int k);
    logic [DW-1:0] c;
    c = req_cur[k*DW +: DW];
    return int'($signed(c));
  endfunction

  function automatic int pick_grant();
    if (rst !== 1'b1 || !m_run) return -1;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_rr + i) % NR;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    int g;
    if (!m_known) return;
    g = pick_grant();
    chk("req_ready", longint'(req_ready), (g < 0) ? 0 : (longint'(1) << g));
    chk("i_stim", longint'($signed(i_stim)), m_stim);
    chk("init_done", longint'(init_done), m_done);
`ifdef STIM_STATS_EN
    chk("grant_cnt", grant_cnt, m_gcnt);
    chk("drop_cnt", drop_cnt, m_dcnt);
    chk("sat_cnt", sat_cnt, m_scnt);
`endif
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    int g, id, c, raw, s, nstim;
    bit dlv, coll;
    if (rst !== 1'b1) begin
      m_known = 1'b1; m_run = 1'b0; m_done = 1'b0; m_init_left = N;
      m_rr = 0; m_stim = 0; m_last_grant = -1;
      m_gcnt = 0; m_dcnt = 0; m_scnt = 0;
      for (int i = 0; i < N; i++) m_acc[i] = 0;
      return;
    end
    if (!m_run) begin
      m_stim = 0; m_last_grant = -1;
      m_init_left--;
      if (m_init_left == 0) begin m_run = 1'b1; m_done = 1'b1; end
      return;
    end
    g = pick_grant();
    m_last_grant = g;
    s = int'(slot_id);
    dlv = slot_valid && (s < N);
    coll = 1'b0;
    nstim = 0;
    if (g >= 0) begin
      m_gcnt++;
      m_rr = (g + 1) % NR;
      id = id_of(g);
      c  = cur_of(g);
      if (id >= N) begin
        m_dcnt++;
      end else begin
        raw = m_acc[id] + c;
        if (raw != sat16(raw)) m_scnt++;
        if (dlv && id == s) begin
          coll = 1'b1; nstim = sat16(raw); m_acc[id] = 0;
        end else begin
          m_acc[id] = sat16(raw);
        end
      end
    end
    if (dlv && !coll) begin
      nstim = m_acc[s]; m_acc[s] = 0;
    end
    m_stim = nstim;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit v, input int id, input int cur);
    req_valid[k] = v;
    req_id[k*IW +: IW] = IW'(id);
    req_cur[k*DW +: DW] = DW'(cur);
  endtask

  task automatic wait_init(input string name);
    int cnt;
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 600) begin
      cycle();
      cnt++;
    end
    chk(name, cnt, 500);
  endtask

  task automatic sweep_all();
    for (int s = 0; s < N; s++) begin
      slot_id = IW'(s); slot_valid = 1'b1;
      cycle();
    end
    slot_valid = 1'b0;
  endtask

  initial begin
    int exp_seq1 [8];
    int exp_seq2 [6];
    logic [15:0] r16;
    int rid, rcur;
`ifdef STIM_STATS_EN
    logic [31:0] sat0, drop0;
`endif
    exp_seq1 = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_seq2 = '{2, 3, 0, 2, 3, 0};

    rst = 1'b0; req_valid = '0; req_id = '0; req_cur = '0;
    slot_id = '0; slot_valid = 1'b0;
    @(posedge clk); #1;

    // Reset held low for 3 edges, then INIT with requesters knocking
    repeat (3) cycle();
    rst = 1'b1;
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, k, 0);
    #1;
    chk("ready_in_init", longint'(req_ready), 0);
    chk("stim_in_init", longint'(i_stim), 0);
    repeat (10) cycle();
    req_valid = '0;
    begin
      int cnt;
      cnt = 10;
      while (init_done !== 1'b1 && cnt < 600) begin
        cycle();
        cnt++;
      end
      chk("init_length", cnt, 500);
    end

    // Single inject to neuron 150, then two slot sweeps
    set_req(0, 1'b1, 150, 4096);
    #1;
    chk("single_ready", longint'(req_ready), 1);
    cycle();
    req_valid = '0;
    for (int sw = 0; sw < 2; sw++) begin
      for (int s = 0; s < N; s++) begin
        slot_id = IW'(s); slot_valid = 1'b1;
        cycle();
        if (s == 150) chk((sw == 0) ? "sweep1_slot150" : "sweep2_slot150",
                          longint'($signed(i_stim)), (sw == 0) ? 4096 : 0);
        if (s == 151 && sw == 0) chk("sweep1_slot151", longint'($signed(i_stim)), 0);
      end
    end
    slot_valid = 1'b0;

    // Round robin: pointer sits at 1 after the single grant to requester 0
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 10 + k, 1);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_all_valid", longint'(req_ready), longint'(1) << exp_seq1[i]);
      cycle();
    end
    req_valid[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_req1_idle", longint'(req_ready), longint'(1) << exp_seq2[i]);
      cycle();
    end
    req_valid = '0;

    // Saturation at both rails on neuron 7
`ifdef STIM_STATS_EN
    sat0 = sat_cnt;
`endif
    set_req(0, 1'b1, 7, 24576);
    cycle(); cycle();
    req_valid = '0;
    slot_id = IW'(7); slot_valid = 1'b1;
    cycle();
    chk("sat_positive", longint'(i_stim), 32767);
    slot_valid = 1'b0;
    set_req(0, 1'b1, 7, -24576);
    cycle(); cycle();
    req_valid = '0;
    slot_valid = 1'b1;
    cycle();
    chk("sat_negative", longint'(i_stim), 32768);
    slot_valid = 1'b0;
`ifdef STIM_STATS_EN
    chk("sat_cnt_delta", longint'(sat_cnt - sat0), 2);
`endif

    // Collision on neuron 20
    set_req(0, 1'b1, 20, 50);
    cycle();
    set_req(0, 1'b1, 20, 100);
    slot_id = IW'(20); slot_valid = 1'b1;
    cycle();
    req_valid = '0;
    chk("collision", longint'($signed(i_stim)), 150);
    cycle();
    chk("collision_next", longint'($signed(i_stim)), 0);
    slot_valid = 1'b0;

    // Out-of-range id (largest encodable id, beyond the neuron count)
`ifdef STIM_STATS_EN
    drop0 = drop_cnt;
`endif
    set_req(0, 1'b1, 511, 1000);
    #1;
    chk("oor_ready", longint'(req_ready), 1);
    cycle();
    req_valid = '0;
    sweep_all();
`ifdef STIM_STATS_EN
    chk("drop_cnt_delta", longint'(drop_cnt - drop0), 1);
`endif

    // Reset mid-run discards pending current on neuron 9
    set_req(0, 1'b1, 9, 300);
    cycle();
    req_valid = '0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wait_init("reinit_length");
    slot_id = IW'(9); slot_valid = 1'b1;
    cycle();
    chk("slot9_after_reset", longint'(i_stim), 0);
    slot_valid = 1'b0;

    // Randomized traffic obeying the hold-until-ready protocol
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < NR; k++) begin
        if (!req_valid[k] || k == m_last_grant) begin
          if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 9) == 0) rid = $urandom_range(500, 511);
            else rid = $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) begin
              r16 = 16'($urandom);
              rcur = int'($signed(r16));
            end else begin
              rcur = int'($urandom_range(0, 400)) - 200;
            end
            set_req(k, 1'b1, rid, rcur);
          end else begin
            req_valid[k] = 1'b0;
          end
        end
      end
      slot_valid = ($urandom_range(0, 3) != 0);
      slot_id = IW'($urandom_range(0, 31));
      rst = (cyc == 2000) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
